match_sequencer: RTL

- Top-level match controller for the coprocessor complex.
- Tracks the match phase (idle, countdown, play, respawn, game over) and freezes both physics coprocessors outside live play.
- Detects blast-zone KOs from packed player positions, owns both lives counters, and issues respawn pulses.
- Sits beside the MMIO block: lives outputs feed the lives registers and the VGA damage/lives word; freeze outputs gate the physics freeze inputs.

---
 rtl/match_sequencer_pkg.sv | 29 ++
 rtl/match_sequencer_frame_ticker.sv | 28 ++
 rtl/match_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/match_sequencer_pkg.sv
// Shared definitions for the match controller: phase encoding, winner codes and
// the packed player-position field layout.
package match_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StRespawn   = 3'd3,
    StGameOver  = 3'd4
  } phase_e;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;
  localparam logic [1:0] WinDraw = 2'b11;

  localparam int unsigned X_HI = 31;
  localparam int unsigned X_LO = 16;
  localparam int unsigned Y_HI = 15;
  localparam int unsigned Y_LO = 0;

  // True when a packed position lies beyond either blast line (unsigned compare).
  function automatic logic blast_ko(input logic [31:0] pos, input int unsigned x_max,
                                    input int unsigned y_max);
    return ({16'd0, pos[X_HI:X_LO]} > x_max) || ({16'd0, pos[Y_HI:Y_LO]} > y_max);
  endfunction

endpackage

// File: rtl/match_sequencer_frame_ticker.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks, in the
// cycle where the count sits at FRAME_DIV-1.
module frame_ticker #(
  parameter int unsigned FRAME_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(FRAME_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (count_q == Last) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick = (count_q == Last);

endmodule

// File: rtl/match_sequencer.sv
// Match phase controller: countdown, live play, KO/respawn handling and game
// over, stepping only on frame ticks; freezes physics outside live play.
module match_sequencer
  import match_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_DIV        = 50000,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned RESPAWN_FRAMES   = 120,
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned BLAST_X_MAX      = 640,
  parameter int unsigned BLAST_Y_MAX      = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pos_p1,
  input  logic [31:0] pos_p2,
  output logic        freeze_p1,
  output logic        freeze_p2,
  output logic        respawn_p1,
  output logic        respawn_p2,
  output logic [31:0] lives_p1,
  output logic [31:0] lives_p2,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic [7:0]  timer,
  output logic        frame_tick
);

  // Zero-length phases still last one frame.
  localparam logic [31:0] CdFrames = (COUNTDOWN_FRAMES == 0) ? 32'd1 : 32'(COUNTDOWN_FRAMES);
  localparam logic [31:0] RsFrames = (RESPAWN_FRAMES == 0) ? 32'd1 : 32'(RESPAWN_FRAMES);
  localparam logic [31:0] Lives0   = 32'(START_LIVES);

  phase_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] lives_p1_q, lives_p1_d, lives_p2_q, lives_p2_d;
  logic [1:0]  winner_q, winner_d;
  logic        respawn_p1_q, respawn_p1_d, respawn_p2_q, respawn_p2_d;
  logic        tick, ko_p1, ko_p2;
  logic [31:0] lives_p1_dec, lives_p2_dec;

  frame_ticker #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_ticker (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign ko_p1 = blast_ko(pos_p1, BLAST_X_MAX, BLAST_Y_MAX);
  assign ko_p2 = blast_ko(pos_p2, BLAST_X_MAX, BLAST_Y_MAX);

  assign lives_p1_dec = (ko_p1 && lives_p1_q != '0) ? lives_p1_q - 32'd1 : lives_p1_q;
  assign lives_p2_dec = (ko_p2 && lives_p2_q != '0) ? lives_p2_q - 32'd1 : lives_p2_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    lives_p1_d   = lives_p1_q;
    lives_p2_d   = lives_p2_q;
    winner_d     = winner_q;
    respawn_p1_d = 1'b0;
    respawn_p2_d = 1'b0;
    if (tick) begin
      case (state_q)
        StIdle, StGameOver: begin
          if (start) begin
            state_d    = StCountdown;
            timer_d    = CdFrames;
            lives_p1_d = Lives0;
            lives_p2_d = Lives0;
            winner_d   = WinNone;
          end
        end
        StCountdown, StRespawn: begin
          if (timer_q <= 32'd1) begin
            state_d = StPlay;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        StPlay: begin
          if (ko_p1 || ko_p2) begin
            lives_p1_d = lives_p1_dec;
            lives_p2_d = lives_p2_dec;
            if (lives_p1_dec == '0 && lives_p2_dec == '0) begin
              state_d  = StGameOver;
              winner_d = WinDraw;
            end else if (lives_p1_dec == '0) begin
              state_d  = StGameOver;
              winner_d = WinP2;
            end else if (lives_p2_dec == '0) begin
              state_d  = StGameOver;
              winner_d = WinP1;
            end else begin
              state_d      = StRespawn;
              timer_d      = RsFrames;
              respawn_p1_d = ko_p1;
              respawn_p2_d = ko_p2;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      lives_p1_q   <= Lives0;
      lives_p2_q   <= Lives0;
      winner_q     <= WinNone;
      respawn_p1_q <= 1'b0;
      respawn_p2_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lives_p1_q   <= lives_p1_d;
      lives_p2_q   <= lives_p2_d;
      winner_q     <= winner_d;
      respawn_p1_q <= respawn_p1_d;
      respawn_p2_q <= respawn_p2_d;
    end
  end

  assign state      = state_q;
  assign winner     = winner_q;
  assign timer      = (timer_q > 32'd255) ? 8'hFF : timer_q[7:0];
  assign lives_p1   = lives_p1_q;
  assign lives_p2   = lives_p2_q;
  assign freeze_p1  = (state_q != StPlay);
  assign freeze_p2  = (state_q != StPlay);
  assign respawn_p1 = respawn_p1_q;
  assign respawn_p2 = respawn_p2_q;
  assign frame_tick = tick;

endmodule
